// File: rtl/inmp441_i2s_capture.sv
// I2S master receiver for an INMP441 microphone: generates SCK/WS and captures
// the 24-bit left-slot sample once per 64-bit frame.
module inmp441_i2s_capture #(
  parameter int clk_mhz         = 65,
  parameter int sck_half_period = 16,
  parameter int sync_stages     = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        cs,
  output logic        sck,
  input  logic        sdo,
  output logic [23:0] value,
  output logic        value_we
);

  if (sck_half_period < 2 || sck_half_period > 255 || sync_stages < 1 || clk_mhz < 1) begin : g_bad_param
    $error("inmp441_i2s_capture: illegal parameter value");
  end

  localparam logic [7:0] DIV_LAST = 8'(sck_half_period - 1);

  logic [7:0]             div_cnt;
  logic [5:0]             bit_cnt;
  logic [5:0]             bit_cnt_next;
  logic                   first_frame;
  logic                   div_tc;
  logic                   rise_evt;
  logic                   fall_evt;
  logic                   take_bit;
  logic                   last_bit;
  logic [sync_stages-1:0] sdo_sync;
  logic [sync_stages-1:0] take_vld;
  logic [sync_stages-1:0] last_vld;
  logic [23:0]            shreg_p0;
  logic                   vld_p0;

  always_comb begin
    div_tc       = (div_cnt == DIV_LAST);
    rise_evt     = div_tc & ~sck;
    fall_evt     = div_tc & sck;
    bit_cnt_next = bit_cnt + 6'd1;
    // Left-slot data occupies bits 1..24: one SCK after the WS transition, MSB first.
    take_bit     = rise_evt && (bit_cnt >= 6'd1) && (bit_cnt <= 6'd24);
    last_bit     = rise_evt && (bit_cnt == 6'd24) && !first_frame;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt     <= '0;
      sck         <= 1'b0;
      bit_cnt     <= '0;
      cs          <= 1'b0;
      first_frame <= 1'b1;
      sdo_sync    <= '0;
      take_vld    <= '0;
      last_vld    <= '0;
      shreg_p0    <= '0;
      vld_p0      <= 1'b0;
      value       <= '0;
      value_we    <= 1'b0;
    end else begin
      if (div_tc) begin
        div_cnt <= '0;
        sck     <= ~sck;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end

      if (fall_evt) begin
        bit_cnt <= bit_cnt_next;
        cs      <= bit_cnt_next[5];
        if (bit_cnt == 6'd63) first_frame <= 1'b0;
      end

      // Sample strobes travel alongside sdo through the synchroniser depth.
      sdo_sync[0] <= sdo;
      take_vld[0] <= take_bit;
      last_vld[0] <= last_bit;
      for (int i = 1; i < sync_stages; i++) begin
        sdo_sync[i] <= sdo_sync[i-1];
        take_vld[i] <= take_vld[i-1];
        last_vld[i] <= last_vld[i-1];
      end

      // Stage p0: shift register fed from the synchroniser output.
      if (take_vld[sync_stages-1]) shreg_p0 <= {shreg_p0[22:0], sdo_sync[sync_stages-1]};
      vld_p0 <= last_vld[sync_stages-1];

      // Output stage: publish the completed word one cycle after its last bit.
      value_we <= vld_p0;
      if (vld_p0) value <= shreg_p0;
    end
  end

endmodule

// File: tb/tb_inmp441_i2s_capture.sv
// Scoreboard bench for inmp441_i2s_capture: a mic model serialises directed
// frames, expected samples are queued at issue and checked on value_we.
module tb_inmp441_i2s_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sdo = 1'b0;
  logic        cs, sck, value_we;
  logic [23:0] value;

  logic        reset4 = 1'b1;
  logic        sdo4 = 1'b0;
  logic        cs4, sck4, value_we4;
  logic [23:0] value4;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic done = 1'b0;

  logic [23:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inmp441_i2s_capture dut (
    .clk(clk), .reset(reset), .cs(cs), .sck(sck), .sdo(sdo),
    .value(value), .value_we(value_we)
  );

  inmp441_i2s_capture #(.sck_half_period(4)) dut4 (
    .clk(clk), .reset(reset4), .cs(cs4), .sck(sck4), .sdo(sdo4),
    .value(value4), .value_we(value_we4)
  );

  function automatic logic mic_bit(int idx, logic [23:0] l, logic [23:0] r);
    if (idx >= 1 && idx <= 24) return l[24-idx];
    if (idx >= 33 && idx <= 56) return r[56-idx];
    return 1'b0;
  endfunction

  // Reset as seen by the DUTs (sampled on the same edge)
  logic rst_q = 1'b1;
  logic rst4_q = 1'b1;
  always @(posedge clk) begin
    rst_q  <= reset;
    rst4_q <= reset4;
  end

  // Mic model for the main DUT: new bit driven after each SCK falling edge
  logic [23:0] cur_l = '0;
  logic [23:0] cur_r = '0;
  int   idx = 0;
  int   frame_cnt = 0;
  int   rise24_cyc = -100000;
  logic mic_sck_q = 1'b0;
  always @(negedge clk) begin
    if (rst_q) begin
      idx = 0;
      sdo = 1'b0;
    end else if (mic_sck_q && !sck) begin
      idx = (idx + 1) % 64;
      if (idx == 0) frame_cnt++;
      sdo = mic_bit(idx, cur_l, cur_r);
    end else if (!mic_sck_q && sck && idx == 24) begin
      rise24_cyc = cyc;
    end
    mic_sck_q = sck;
  end

  // Mic model for the short-divider instance: constant left word
  int   idx4 = 0;
  logic mic4_sck_q = 1'b0;
  always @(negedge clk) begin
    if (rst4_q) begin
      idx4 = 0;
      sdo4 = 1'b0;
    end else if (mic4_sck_q && !sck4) begin
      idx4 = (idx4 + 1) % 64;
      sdo4 = mic_bit(idx4, 24'h0F0F0F, 24'h000000);
    end
    mic4_sck_q = sck4;
  end

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  // Monitor / scoreboard for both instances
  logic sck_m = 1'b0, cs_m = 1'b0, we_m = 1'b0;
  int   rel_cyc = 0, last_rise = -1, last_pulse = -1, cs_edge = -1;
  logic sck4_m = 1'b0, we4_m = 1'b0;
  int   rel4_cyc = 0, last_rise4 = -1, last_pulse4 = -1, pulses4 = 0;
  always @(negedge clk) begin
    if (rst_q) begin
      chk("reset_cs", {31'b0, cs}, 32'd0);
      chk("reset_sck", {31'b0, sck}, 32'd0);
      chk("reset_value", {8'b0, value}, 32'd0);
      chk("reset_value_we", {31'b0, value_we}, 32'd0);
      rel_cyc = cyc;
      last_rise = -1;
      last_pulse = -1;
      cs_edge = -1;
    end else begin
      if (sck && !sck_m) begin
        if (last_rise < 0) chk("first_sck_rise", cyc - rel_cyc, 32'd16);
        else chk("sck_period", cyc - last_rise, 32'd32);
        last_rise = cyc;
      end
      if (!sck && sck_m) chk("sck_high_time", cyc - last_rise, 32'd16);
      if (cs !== cs_m) begin
        chk("cs_on_sck_fall", {30'b0, sck_m, sck}, 32'd2);
        if (cs_edge >= 0) chk(cs ? "cs_low_time" : "cs_high_time", cyc - cs_edge, 32'd1024);
        cs_edge = cyc;
      end
      if (value_we) begin
        if (we_m) begin
          chk("value_we_width", {31'b0, we_m}, 32'd0);
        end else begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: value %0h with no sample queued", value);
          end else begin
            chk("value", {8'b0, value}, {8'b0, exp_q.pop_front()});
          end
          chk("pulse_latency", cyc - rise24_cyc, 32'd3);
          if (last_pulse >= 0) chk("pulse_spacing", cyc - last_pulse, 32'd2048);
          else chk("first_pulse_time", cyc - rel_cyc, 32'd2835);
          last_pulse = cyc;
        end
      end
    end
    sck_m = sck;
    cs_m  = cs;
    we_m  = value_we;

    if (rst4_q) begin
      rel4_cyc = cyc;
      last_rise4 = -1;
      last_pulse4 = -1;
    end else begin
      if (sck4 && !sck4_m) begin
        if (last_rise4 < 0) chk("p4_first_sck_rise", cyc - rel4_cyc, 32'd4);
        else chk("p4_sck_period", cyc - last_rise4, 32'd8);
        last_rise4 = cyc;
      end
      if (value_we4 && !we4_m) begin
        pulses4++;
        chk("p4_value", {8'b0, value4}, 32'h000F0F0F);
        if (last_pulse4 >= 0) chk("p4_pulse_spacing", cyc - last_pulse4, 32'd512);
        else chk("p4_first_pulse_time", cyc - rel4_cyc, 32'd711);
        last_pulse4 = cyc;
      end
      if (value_we4 && we4_m) chk("p4_value_we_width", {31'b0, we4_m}, 32'd0);
    end
    sck4_m = sck4;
    we4_m  = value_we4;

    if (done) begin
      chk("all_samples_seen", exp_q.size(), 32'd0);
      chk("p4_pulses_seen", {31'b0, (pulses4 >= 3)}, 32'd1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  task automatic wait_wrap();
    int start = frame_cnt;
    int n = 0;
    while (frame_cnt == start && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (frame_cnt == start) begin
      $display("FAIL frame_wrap_timeout: no frame boundary within %0d cycles", n);
      $fatal(1, "frame boundary timeout");
    end
  endtask

  task automatic send_frame(logic [23:0] l, logic [23:0] r, bit expect_pulse);
    cur_l = l;
    cur_r = r;
    if (expect_pulse) exp_q.push_back(l);
    wait_wrap();
  endtask

  initial begin
    cur_l = 24'h123456;
    cur_r = 24'hFFFFFF;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    wait_wrap();                               // first frame: suppressed
    send_frame(24'h123456, 24'hFFFFFF, 1'b1);
    send_frame(24'h800000, 24'h000000, 1'b1);
    send_frame(24'h7FFFFF, 24'h000000, 1'b1);
    send_frame(24'h000001, 24'h000000, 1'b1);
    send_frame(24'hFFFFFF, 24'h000000, 1'b1);
    send_frame(24'h000000, 24'hABCDEF, 1'b1);
    send_frame(24'h000000, 24'hABCDEF, 1'b1);
    // Interrupt a left slot at bit 12
    cur_l = 24'h111111;
    cur_r = 24'h000000;
    for (int n = 0; n < 5000 && idx != 12; n++) @(negedge clk);
    if (idx != 12) begin
      $display("FAIL bit12_timeout: mic index %0d expected 12", idx);
      $fatal(1, "bit 12 timeout");
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    send_frame(24'h5A5A5A, 24'h000000, 1'b0);
    send_frame(24'h5A5A5A, 24'h000000, 1'b1);
    repeat (10) @(negedge clk);
    done = 1'b1;
  end

  initial begin
    repeat (5) @(negedge clk);
    reset4 = 1'b0;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/inmp441_i2s_capture.md
Name: inmp441_i2s_capture

Overview:
- I2S master receiver for an INMP441 MEMS microphone, running on the 65 MHz system clock.
- Generates the serial bit clock (sck) and word select (cs, the WS pin) and deserialises the mic's 24-bit left-channel samples into `value`, with a one-cycle `value_we` strobe per sample.
- Sits between the board GPIO pins and the lab logic's `mic` / `mic_we` inputs. The mic's L/R pin is tied low externally, so the mic drives the left slot.

Parameters:
- clk_mhz, 65: system clock frequency; informational only, no logic depends on it.
- sck_half_period, 16: clk cycles per SCK half period. Default gives SCK = 65/32 ≈ 2.03 MHz and fs = SCK/64 ≈ 31.7 kHz. Legal range 2..255.
- sync_stages, 2: flip-flop stages on the sdo input synchroniser.

Ports:
- clk, input, 1: system clock; all logic on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- cs, output, 1: I2S word select (WS) to the mic; 0 = left slot, 1 = right slot.
- sck, output, 1: I2S bit clock to the mic; registered output.
- sdo, input, 1: serial data from the mic; asynchronous to clk.
- value, output, 24: last captured sample, two's complement.
- value_we, output, 1: one-clk pulse when `value` is updated.

Behaviour:
- Reset values: sck=0, cs=0, value=0, value_we=0, divider=0, bit_cnt=0, shift register=0, first_frame flag=1, synchroniser flops=0.
- Divider:
  - Counts 0..sck_half_period-1; at the terminal count it wraps to 0 and toggles sck.
  - After reset is released, sck stays low for exactly sck_half_period cycles and then rises.
  - SCK period is 2*sck_half_period clk cycles with exact 50% duty.
- Bit counter (6 bits, 0..63):
  - Increments, wrapping 63→0, in the same clk cycle that sck is driven low (the falling event).
  - cs is registered together with it: cs ← bit_cnt_next[5].
  - So cs is low for SCK bits 0..31 and high for bits 32..63. cs changes only coincident with SCK falling edges.
  - Frame = 64 SCK periods = 64*2*sck_half_period clk cycles.
- Data sampling:
  - sdo passes through the sync_stages synchroniser.
  - A rise event is the clk cycle in which sck is driven high. The sample for that rise event is taken sync_stages cycles later from the synchroniser output, still well before the next falling edge.
  - Bits are sampled only while bit_cnt is 1..24 (one SCK delay after the WS transition, MSB first). The sample shifts into the LSB of a 24-bit shift register.
  - Bits 0 and 25..63, including the whole right slot, are ignored.
- Output update:
  - In the clk cycle after the bit_cnt=24 sample is shifted in, value ← shift register and value_we=1 for exactly one cycle. value holds until the next update.
  - Result: bit sampled at index 1 = value[23], bit sampled at index 24 = value[0].
- First frame suppression:
  - The first frame after reset (bit_cnt 0..63 before the first wrap) produces no value_we, and value stays 0.
  - first_frame clears on the first 63→0 wrap.
  - Exactly one value_we pulse per frame follows thereafter.
- Reset mid-frame: all state returns to reset values on the next clk edge. Partial samples are discarded, and the first-frame suppression applies again.
- No combinational path from sdo to any output.

Test Plan:
1. Reset check. Assert reset 5 cycles, release → cs=0, sck=0, value=0, value_we=0. First sck rise occurs exactly 16 clk after release. sck period measures 32 clk; cs period measures 2048 clk with 1024 low / 1024 high. cs edges always coincide with sck falling edges.
2. Basic capture. The bench mic model drives sdo on each sck falling edge: left slot data = 0x123456 (MSB in bit 1), right slot = 0xFFFFFF, padding 0. Frame 1 gives no value_we. Frame 2 gives value=0x123456 with a single 1-cycle value_we pulse, asserted sync_stages+1 clk after the bit-24 rise event.
3. Sign and extremes. Consecutive frames of 0x800000, 0x7FFFFF, 0x000001, 0xFFFFFF → value follows the same sequence, one pulse per frame, pulse spacing exactly 2048 clk.
4. Right-slot isolation. Left = 0x000000, right = 0xABCDEF → value stays 0x000000 and pulses continue each frame.
5. Reset mid-frame. Assert reset for 1 cycle during bit 12 of a left slot → no pulse for the interrupted frame or the following frame. Sampling then resumes correctly, e.g. value=0x5A5A5A.
6. Parameter check. With sck_half_period=4 → sck period 8 clk, frame 512 clk, capture of 0x0F0F0F correct.
